stopwatch_ctrl: RTL

- Mode controller between the button debouncer and the minutes/seconds counter datapath of the stopwatch.
- Synchronises the debounced rstBtn/pueBtn/sel/adj levels into the fast clock domain and runs the STOP/RUN/ADJ mode state machine.
- Schedules one-cycle increment/clear commands to the counters from externally supplied tick enables.
- Drives the digit-blink mask used by the display mux.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/sync_edge.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch mode controller.
// Mode encoding doubles as the debug/LED value on the mode port.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        ADJ  = 2'd2
    } mode_e;

    localparam logic [1:0] MASK_MIN  = 2'b10;
    localparam logic [1:0] MASK_SEC  = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b00;

endpackage

// File: rtl/sync_edge.sv
// Level synchroniser with one history flop for edge detection.
// rise_o/change_o are combinational against the history flop.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic change_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o  = sync_q[STAGES-1];
    assign rise_o   = level_o & ~hist_q;
    assign change_o = level_o ^ hist_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// STOP/RUN/ADJ mode controller issuing one-cycle counter commands.
// Commands are decoded from the state held at the start of the cycle.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       validRstBtn,
    input  logic       validPueBtn,
    input  logic       validSel,
    input  logic       validAdj,
    input  logic       tick1Hz,
    input  logic       tick2Hz,
    input  logic       tickBlink,
    input  logic       secMax,
    output logic       incSec,
    output logic       incMin,
    output logic       clrAll,
    output logic [1:0] blinkMask,
    output logic [1:0] mode,
    output logic       running
);

    logic rstPress, puePress, sel, adj;
    logic rst_level_unused, rst_chg_unused;
    logic pue_level_unused, pue_rise_unused;
    logic sel_rise_unused, sel_chg_unused;
    logic adj_rise_unused, adj_chg_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_rst (
        .clk(clk), .rstN(rstN), .d_i(validRstBtn),
        .level_o(rst_level_unused), .rise_o(rstPress),
        .change_o(rst_chg_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_pue (
        .clk(clk), .rstN(rstN), .d_i(validPueBtn),
        .level_o(pue_level_unused), .rise_o(pue_rise_unused),
        .change_o(puePress)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sel (
        .clk(clk), .rstN(rstN), .d_i(validSel),
        .level_o(sel), .rise_o(sel_rise_unused),
        .change_o(sel_chg_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_adj (
        .clk(clk), .rstN(rstN), .d_i(validAdj),
        .level_o(adj), .rise_o(adj_rise_unused),
        .change_o(adj_chg_unused)
    );

    mode_e state_q, state_d;
    logic  runFlag_q, runFlag_d;
    logic  phase_q, phase_d;
    logic  incSec_q, incSec_d;
    logic  incMin_q, incMin_d;
    logic  clrAll_q, clrAll_d;

    always_comb begin
        state_d   = STOP;
        runFlag_d = runFlag_q;
        phase_d   = 1'b0;
        incSec_d  = 1'b0;
        incMin_d  = 1'b0;
        clrAll_d  = 1'b0;

        case (state_q)
            RUN: begin
                if (tick1Hz) begin
                    incSec_d = 1'b1;
                    incMin_d = secMax;
                end
            end
            ADJ: begin
                phase_d = phase_q ^ tickBlink;
                if (tick2Hz) begin
                    incMin_d = sel;
                    incSec_d = ~sel;
                end
            end
            default: ;
        endcase

        // Reset press wins over everything, including ticks seen this cycle.
        if (rstPress) begin
            clrAll_d  = 1'b1;
            incSec_d  = 1'b0;
            incMin_d  = 1'b0;
            runFlag_d = 1'b0;
            state_d   = adj ? ADJ : STOP;
        end else if (adj) begin
            runFlag_d = runFlag_q ^ puePress;
            state_d   = ADJ;
        end else begin
            runFlag_d = runFlag_q ^ puePress;
            state_d   = runFlag_d ? RUN : STOP;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= STOP;
            runFlag_q <= 1'b0;
            phase_q   <= 1'b0;
            incSec_q  <= 1'b0;
            incMin_q  <= 1'b0;
            clrAll_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            runFlag_q <= runFlag_d;
            phase_q   <= phase_d;
            incSec_q  <= incSec_d;
            incMin_q  <= incMin_d;
            clrAll_q  <= clrAll_d;
        end
    end

    assign incSec    = incSec_q;
    assign incMin    = incMin_q;
    assign clrAll    = clrAll_q;
    assign mode      = state_q;
    assign running   = runFlag_q;
    assign blinkMask = (state_q == ADJ && phase_q)
                     ? (sel ? MASK_MIN : MASK_SEC) : MASK_NONE;

endmodule
